// File: rtl/io_input_ctrl_pkg.sv
// io_input_ctrl_pkg: shared widths, register map and status-word layout for the input controller.
package io_input_ctrl_pkg;
   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] KEY_ADDR   = 32'hFFFFF080;
   localparam logic [DATA_W-1:0] KCTRL_ADDR = 32'hFFFFF084;
   localparam logic [DATA_W-1:0] SW_ADDR    = 32'hFFFFF090;
   localparam logic [DATA_W-1:0] SCTRL_ADDR = 32'hFFFFF094;
   localparam logic [DATA_W-1:0] FILL       = 32'hDEADDEAD;
   localparam int READY   = 0;
   localparam int OVERRUN = 1;

   function automatic logic [DATA_W-1:0] status_word(input logic rdy, input logic ovr);
      status_word = '0;
      status_word[READY] = rdy;
      status_word[OVERRUN] = ovr;
   endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchronizer plus stability counter; db follows an input only after it holds steady.
module io_debounce #(
   parameter int WIDTH    = 4,
   parameter int DEBOUNCE = 4,
   parameter int CNTBITS  = 3
) (
   input  logic             clk2,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] db,
   output logic             changed,
   output logic             rose
);
   localparam logic [CNTBITS-1:0] LAST = CNTBITS'(DEBOUNCE - 1);
   logic [WIDTH-1:0]   sync1, sync2, cand;
   logic [CNTBITS-1:0] cnt;
   logic               settle;

   // settle marks the edge on which db is loaded from cand
   assign settle  = sync2 == cand && cnt == LAST;
   assign changed = settle && cand != db;
   assign rose    = settle && |(cand & ~db);

   always_ff @(posedge clk2 or posedge reset)
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         cand  <= '0;
         cnt   <= '0;
         db    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
         end else if (cnt != LAST)
            cnt <= cnt + CNTBITS'(1);
         else
            db <= cand;
      end
endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped KEY/SW controller with debounce, sticky ready/overrun flags and registered reads.
module io_input_ctrl
   import io_input_ctrl_pkg::*;
#(
   parameter int               DBITS     = DATA_W,
   parameter int               DEBOUNCE  = 50000,
   parameter int               CNTBITS   = 16,
   parameter logic [DBITS-1:0] ADDRKEY   = KEY_ADDR,
   parameter logic [DBITS-1:0] ADDRKCTRL = KCTRL_ADDR,
   parameter logic [DBITS-1:0] ADDRSW    = SW_ADDR,
   parameter logic [DBITS-1:0] ADDRSCTRL = SCTRL_ADDR
) (
   input  logic             clk2,
   input  logic             reset,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   input  logic             bus_stb,
   input  logic [DBITS-1:0] bus_addr,
   input  logic             bus_we,
   input  logic [DBITS-1:0] bus_wdata,
   output logic [DBITS-1:0] bus_rdata,
   output logic             bus_hit,
   output logic [3:0]       key_db,
   output logic [9:0]       sw_db
);
   logic             k_chg, k_rose, s_chg, s_rose, hit, unused;
   logic [1:0]       is_d, is_c, ev, clr_r, clr_o, rdy, ovr;
   logic [DBITS-1:0] rd;

   io_debounce #(.WIDTH(4), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_key (
      .clk2(clk2), .reset(reset), .raw(~KEY), .db(key_db), .changed(k_chg), .rose(k_rose)
   );

   io_debounce #(.WIDTH(10), .DEBOUNCE(DEBOUNCE), .CNTBITS(CNTBITS)) u_sw (
      .clk2(clk2), .reset(reset), .raw(SW), .db(sw_db), .changed(s_chg), .rose(s_rose)
   );

   assign unused = ^{bus_wdata[DBITS-1:2], k_chg, s_rose};

   // index 0 is the KEY group, index 1 the SW group
   always_comb begin
      is_d  = {bus_addr == ADDRSW, bus_addr == ADDRKEY};
      is_c  = {bus_addr == ADDRSCTRL, bus_addr == ADDRKCTRL};
      hit   = |{is_d, is_c};
      ev    = {s_chg, k_rose};
      rd    = is_d[0] ? DBITS'(key_db) :
              is_d[1] ? DBITS'(sw_db) :
              is_c[0] ? DBITS'(status_word(rdy[0], ovr[0])) :
                        DBITS'(status_word(rdy[1], ovr[1]));
      clr_r = !bus_stb ? 2'b00 : bus_we ? is_c & {2{~bus_wdata[READY]}} : is_d;
      clr_o = bus_stb && bus_we ? is_c & {2{~bus_wdata[OVERRUN]}} : 2'b00;
   end

   // an event outranks a clear; overrun looks at ready before any clear
   always_ff @(posedge clk2 or posedge reset)
      if (reset) begin
         rdy       <= '0;
         ovr       <= '0;
         bus_rdata <= '0;
         bus_hit   <= 1'b0;
      end else begin
         rdy <= ev | (rdy & ~clr_r);
         ovr <= (ev & rdy) | (ovr & ~clr_o);
         if (bus_stb) begin
            bus_hit   <= hit;
            bus_rdata <= !hit ? DBITS'(FILL) : bus_we ? '0 : rd;
         end
      end
endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: directed stimulus with a history-window debounce model checked every cycle.
module tb_io_input_ctrl;
   localparam logic [31:0] A_KEY = 32'hFFFFF080, A_KC = 32'hFFFFF084;
   localparam logic [31:0] A_SW = 32'hFFFFF090, A_SC = 32'hFFFFF094;
   logic        clk2 = 0, reset = 1, bus_stb = 0, bus_we = 0;
   logic [3:0]  KEY = 4'hF;
   logic [9:0]  SW = '0;
   logic [31:0] bus_addr = '0, bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_hit;
   logic [3:0]  key_db;
   logic [9:0]  sw_db;
   int passed = 0, total = 0;

   io_input_ctrl #(.DEBOUNCE(4), .CNTBITS(4)) dut (
      .clk2(clk2), .reset(reset), .KEY(KEY), .SW(SW), .bus_stb(bus_stb), .bus_addr(bus_addr),
      .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_hit(bus_hit),
      .key_db(key_db), .sw_db(sw_db)
   );

   always #5 clk2 = ~clk2;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %h, expected %h", n, a, e);
   endtask

   // Model: a level reaches db once the samples taken 2..6 edges ago all agree.
   logic [6:0][9:0] kh, sh;
   logic [9:0]      mk, ms;
   logic [1:0]      mr, mo;
   logic [31:0]     mrd;
   logic            mhit;

   function automatic logic [9:0] deb(input logic [6:0][9:0] h, input logic [9:0] cur);
      for (int i = 3; i < 7; i++) if (h[i] !== h[2]) return cur;
      return h[2];
   endfunction

   wire [6:0][9:0] nkh = {kh[5:0], {6'b0, ~KEY}};
   wire [6:0][9:0] nsh = {sh[5:0], SW};
   wire [9:0]  nk = deb(nkh, mk);
   wire [9:0]  ns = deb(nsh, ms);
   wire [1:0]  ev = {ns != ms, |(nk & ~mk)};
   wire        mhit_n = bus_addr inside {A_KEY, A_KC, A_SW, A_SC};
   wire [1:0]  rclr = !bus_stb ? 2'b00 :
                      !bus_we ? {bus_addr == A_SW, bus_addr == A_KEY} :
                      {bus_addr == A_SC && !bus_wdata[0], bus_addr == A_KC && !bus_wdata[0]};
   wire [1:0]  oclr = !(bus_stb && bus_we) ? 2'b00 :
                      {bus_addr == A_SC && !bus_wdata[1], bus_addr == A_KC && !bus_wdata[1]};
   wire [31:0] mrd_n = !mhit_n ? 32'hDEADDEAD : bus_we ? 32'h0 :
                       bus_addr == A_KEY ? {22'b0, mk} : bus_addr == A_SW ? {22'b0, ms} :
                       bus_addr == A_KC ? {30'b0, mo[0], mr[0]} : {30'b0, mo[1], mr[1]};

   always @(posedge clk2)
      if (reset) begin
         kh <= '0; sh <= '0; mk <= '0; ms <= '0;
         mr <= '0; mo <= '0; mrd <= '0; mhit <= 1'b0;
      end else begin
         kh <= nkh; sh <= nsh; mk <= nk; ms <= ns;
         mr <= ev | (mr & ~rclr);
         mo <= (ev & mr) | (mo & ~oclr);
         if (bus_stb) begin
            mrd  <= mrd_n;
            mhit <= mhit_n;
         end
      end

   always @(negedge clk2)
      if (!reset) begin
         chk("model key_db", {28'b0, key_db}, {22'b0, mk});
         chk("model sw_db", {22'b0, sw_db}, {22'b0, ms});
         chk("model rdata", bus_rdata, mrd);
         chk("model hit", {31'b0, bus_hit}, {31'b0, mhit});
      end

   task automatic strobe(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus_stb = 1; bus_we = we; bus_addr = a; bus_wdata = d;
      @(negedge clk2);
      bus_stb = 0; bus_we = 0;
   endtask

   initial begin
      @(negedge clk2); @(negedge clk2);
      chk("rst key_db", {28'b0, key_db}, 0);
      chk("rst sw_db", {22'b0, sw_db}, 0);
      chk("rst rdata", bus_rdata, 0);
      chk("rst hit", {31'b0, bus_hit}, 0);
      reset = 0;
      repeat (3) @(negedge clk2);
      KEY = 4'hE;
      repeat (6) @(negedge clk2);
      chk("key edge6", {28'b0, key_db}, 0);
      @(negedge clk2);
      chk("key edge7", {28'b0, key_db}, 32'h1);
      strobe(0, A_KC, 0);
      chk("kctrl ready", bus_rdata, 32'h1);
      chk("kctrl hit", {31'b0, bus_hit}, 1);
      KEY = 4'hF; repeat (10) @(negedge clk2);
      KEY = 4'hD; repeat (10) @(negedge clk2);
      strobe(0, A_KC, 0);
      chk("kctrl overrun", bus_rdata, 32'h3);
      strobe(0, A_KEY, 0);
      chk("key data", bus_rdata, 32'h2);
      strobe(0, A_KC, 0);
      chk("kctrl after read", bus_rdata, 32'h2);
      strobe(1, A_KC, 0);
      chk("kctrl write rdata", bus_rdata, 0);
      strobe(0, A_KC, 0);
      chk("kctrl cleared", bus_rdata, 0);
      KEY = 4'hF; repeat (10) @(negedge clk2);
      KEY = 4'hB; repeat (6) @(negedge clk2);
      strobe(0, A_KEY, 0);
      chk("read on event", bus_rdata, 0);
      chk("key_db on event", {28'b0, key_db}, 32'h4);
      strobe(0, A_KC, 0);
      chk("set wins", bus_rdata, 32'h1);
      strobe(0, 32'hFFFFF088, 0);
      chk("miss rdata", bus_rdata, 32'hDEADDEAD);
      chk("miss hit", {31'b0, bus_hit}, 0);
      SW = 10'h3FF; repeat (10) @(negedge clk2);
      strobe(0, A_SW, 0);
      chk("sw data", bus_rdata, 32'h3FF);
      chk("sw hit", {31'b0, bus_hit}, 1);
      strobe(0, A_SC, 0);
      chk("sctrl after read", bus_rdata, 0);
      strobe(1, A_SW, 32'h55);
      chk("sw write rdata", bus_rdata, 0);
      chk("sw write ignored", {22'b0, sw_db}, 32'h3FF);
      SW = '0; repeat (10) @(negedge clk2);
      strobe(0, A_SW, 0);
      chk("sw back to 0", bus_rdata, 0);
      SW = 10'h155; repeat (4) @(negedge clk2);
      SW = '0; repeat (12) @(negedge clk2);
      chk("glitch sw_db", {22'b0, sw_db}, 0);
      strobe(0, A_SC, 0);
      chk("glitch ready", bus_rdata, 0);
      SW = 10'h2AA; repeat (5) @(negedge clk2);
      #2 reset = 1;
      #1;
      chk("mid rst sw_db", {22'b0, sw_db}, 0);
      chk("mid rst key_db", {28'b0, key_db}, 0);
      chk("mid rst rdata", bus_rdata, 0);
      chk("mid rst hit", {31'b0, bus_hit}, 0);
      @(negedge clk2); @(negedge clk2);
      reset = 0;
      repeat (6) @(negedge clk2);
      chk("post rst edge6", {22'b0, sw_db}, 0);
      @(negedge clk2);
      chk("post rst edge7", {22'b0, sw_db}, 32'h2AA);
      repeat (2) @(negedge clk2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
